// File: rtl/npc_disp_pkg.sv
// Shared display/arbiter definitions for the npc board logic: the active-low
// hex digit table, the blank pattern and the arbitration mode selectors.
package npc_disp_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment patterns, bit0=a .. bit6=g, for hex digits 0..F.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] value);
        return SEG_HEX[value];
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational find-first-set over a request vector.  In fixed mode the
// highest set bit wins; in round-robin mode the scan starts at 'base' and
// wraps, so the caller passes the index just after the previous winner.
module prio_pick
    import npc_disp_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N),
    parameter int MODE  = MODE_FIXED
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] base,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    logic [IDX_W-1:0] pos;

    // Walk the candidates from lowest to highest priority so the last hit is the winner.
    always_comb begin
        found  = |vec;
        idx    = '0;
        pos    = '0;
        if (MODE == MODE_RR) begin
            for (int k = N - 1; k >= 0; k--) begin
                pos = IDX_W'((int'(base) + k) % N);
                if (vec[pos]) begin
                    idx = pos;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end
        onehot = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/prio_enc_queue.sv
// Registered, queued priority encoder.  Requests accumulate in a pending
// register and are issued one index per valid/ready handshake, with either
// fixed or round-robin priority.  Also drives an active-low hex digit of the
// granted index for the board display.
module prio_enc_queue
    import npc_disp_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N),
    parameter int MODE  = MODE_FIXED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             pending_any,
    output logic             dropped,
    output logic [6:0]       seg
);

    logic [N-1:0]     pending_q,     pending_d;
    logic             out_valid_q,   out_valid_d;
    logic [IDX_W-1:0] out_idx_q,     out_idx_d;
    logic [IDX_W-1:0] last_grant_q,  last_grant_d;
    logic             pending_any_q, pending_any_d;
    logic             dropped_q,     dropped_d;
    logic [6:0]       seg_q,         seg_d;

    logic             load;
    logic [IDX_W-1:0] scan_base;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [N-1:0]     pick_onehot;
    logic [N-1:0]     grant_mask;

    prio_pick #(
        .N     (N),
        .IDX_W (IDX_W),
        .MODE  (MODE)
    ) u_pick (
        .vec    (pending_q),
        .base   (scan_base),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Next-state logic: grant on a free or accepted slot, requeue new requests, flush when disabled.
    always_comb begin
        load         = en && (!out_valid_q || out_ready);
        scan_base    = (last_grant_q == IDX_W'(N - 1)) ? '0 : last_grant_q + 1'b1;
        grant_mask   = (load && pick_found) ? pick_onehot : '0;

        pending_d    = pending_q;
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        last_grant_d = last_grant_q;
        dropped_d    = 1'b0;

        if (en) begin
            dropped_d = |(req & pending_q & ~grant_mask);
            pending_d = (pending_q & ~grant_mask) | req;
            if (load) begin
                if (pick_found) begin
                    out_valid_d  = 1'b1;
                    out_idx_d    = pick_idx;
                    last_grant_d = pick_idx;
                end else begin
                    out_valid_d  = 1'b0;
                end
            end
        end else begin
            pending_d   = '0;
            out_valid_d = 1'b0;
        end

        pending_any_d = |pending_d;
        seg_d         = out_valid_d ? hex_seg(4'(out_idx_d)) : SEG_BLANK;
    end

    // State register with synchronous active-low reset; round-robin restarts at index 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q     <= '0;
            out_valid_q   <= 1'b0;
            out_idx_q     <= '0;
            last_grant_q  <= IDX_W'(N - 1);
            pending_any_q <= 1'b0;
            dropped_q     <= 1'b0;
            seg_q         <= SEG_BLANK;
        end else begin
            pending_q     <= pending_d;
            out_valid_q   <= out_valid_d;
            out_idx_q     <= out_idx_d;
            last_grant_q  <= last_grant_d;
            pending_any_q <= pending_any_d;
            dropped_q     <= dropped_d;
            seg_q         <= seg_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_idx     = out_idx_q;
    assign pending_any = pending_any_q;
    assign dropped     = dropped_q;
    assign seg         = seg_q;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Bench for prio_enc_queue: a fixed-priority and a round-robin instance share
// the same stimulus, and each is compared every cycle against a queue model.
module tb_prio_enc_queue;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       outReady;

    logic [1:0] outValid;
    logic [1:0] pendingAny;
    logic [1:0] dropped;
    logic [2:0] outIdx [2];
    logic [6:0] seg [2];

    logic [7:0] mPend [2];
    logic       mValid [2];
    logic [2:0] mIdx [2];
    logic [2:0] mLast [2];
    logic       mDrop [2];

    logic [6:0] segTab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    prio_enc_queue #(.N(8), .IDX_W(3), .MODE(0)) dutFixed (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .out_valid   (outValid[0]),
        .out_ready   (outReady),
        .out_idx     (outIdx[0]),
        .pending_any (pendingAny[0]),
        .dropped     (dropped[0]),
        .seg         (seg[0])
    );

    prio_enc_queue #(.N(8), .IDX_W(3), .MODE(1)) dutRr (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req         (req),
        .out_valid   (outValid[1]),
        .out_ready   (outReady),
        .out_idx     (outIdx[1]),
        .pending_any (pendingAny[1]),
        .dropped     (dropped[1]),
        .seg         (seg[1])
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, got, exp);
        end
    endtask

    // Reference model: pending set of request numbers, pick by priority rule.
    task automatic modelStep();
        for (int m = 0; m < 2; m++) begin
            logic       load;
            logic       found;
            int         sel;
            logic [7:0] taken;
            if (!rst_n) begin
                mPend[m]  = 8'h00;
                mValid[m] = 1'b0;
                mIdx[m]   = 3'd0;
                mLast[m]  = 3'd7;
                mDrop[m]  = 1'b0;
            end else if (!en) begin
                mPend[m]  = 8'h00;
                mValid[m] = 1'b0;
                mDrop[m]  = 1'b0;
            end else begin
                load  = !mValid[m] || outReady;
                found = 1'b0;
                sel   = 0;
                if (m == 0) begin
                    for (int i = 7; i >= 0 && !found; i--) begin
                        if (mPend[m][i]) begin
                            found = 1'b1;
                            sel   = i;
                        end
                    end
                end else begin
                    for (int k = 1; k <= 8 && !found; k++) begin
                        if (mPend[m][(int'(mLast[m]) + k) % 8]) begin
                            found = 1'b1;
                            sel   = (int'(mLast[m]) + k) % 8;
                        end
                    end
                end
                taken = 8'h00;
                if (load && found) taken[sel] = 1'b1;
                mDrop[m] = |(req & mPend[m] & ~taken);
                mPend[m] = (mPend[m] & ~taken) | req;
                if (load) begin
                    mValid[m] = found;
                    if (found) begin
                        mIdx[m]  = 3'(sel);
                        mLast[m] = 3'(sel);
                    end
                end
            end
        end
    endtask

    task automatic checkAll();
        for (int m = 0; m < 2; m++) begin
            logic [6:0] expSeg;
            expSeg = mValid[m] ? segTab[mIdx[m]] : 7'h7F;
            checkOutput($sformatf("m%0d_out_valid", m), 32'(outValid[m]), 32'(mValid[m]));
            checkOutput($sformatf("m%0d_out_idx", m), 32'(outIdx[m]), 32'(mIdx[m]));
            checkOutput($sformatf("m%0d_pending_any", m), 32'(pendingAny[m]), 32'(|mPend[m]));
            checkOutput($sformatf("m%0d_dropped", m), 32'(dropped[m]), 32'(mDrop[m]));
            checkOutput($sformatf("m%0d_seg", m), 32'(seg[m]), 32'(expSeg));
        end
    endtask

    // One clock: drive inputs, let both DUT and model take the edge, then compare.
    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] q, input logic rd);
        rst_n    = r;
        en       = e;
        req      = q;
        outReady = rd;
        @(posedge clk);
        cycle++;
        modelStep();
        #1;
        checkAll();
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        req      = 8'h00;
        outReady = 1'b1;
        for (int m = 0; m < 2; m++) begin
            mPend[m] = 8'h00; mValid[m] = 1'b0; mIdx[m] = 3'd0; mLast[m] = 3'd7; mDrop[m] = 1'b0;
        end
        #2;

        // Reset with all requests asserted, then release and drain.
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);

        // Single-cycle burst drained at full throughput.
        applyStimulus(1'b1, 1'b1, 8'b0010_0110, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);

        // Same burst under backpressure, then release.
        applyStimulus(1'b1, 1'b1, 8'b0010_0110, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);

        // Round-robin sweep and wrap-around patterns.
        applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);
        for (int r = 0; r < 2; r++) begin
            applyStimulus(1'b1, 1'b1, 8'h81, 1'b1);
            for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);
        end

        // Duplicate request while the slot is occupied, and re-request in the grant cycle.
        applyStimulus(1'b1, 1'b1, 8'h01, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h08, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h08, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h08, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h08, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);

        // Flush with work pending and a grant outstanding.
        applyStimulus(1'b1, 1'b1, 8'h0F, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 8'h00, 1'b1);

        // Randomized traffic with occasional flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       e;
            logic [7:0] q;
            logic       rd;
            r  = ($urandom_range(0, 199) != 0);
            e  = ($urandom_range(0, 19) != 0);
            case ($urandom_range(0, 3))
                0:       q = 8'h00;
                1:       q = 8'(1 << $urandom_range(0, 7));
                2:       q = 8'($urandom & $urandom);
                default: q = 8'($urandom);
            endcase
            if ($urandom_range(0, 2) == 0) q = 8'h00;
            rd = ($urandom_range(0, 3) != 0);
            applyStimulus(r, e, q, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
